// File: rtl/window_pkg.sv
// Shared types and constants for the window multiplier: sample/coefficient widths,
// frame lengths and the FIFO beat payload.
package window_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned SAMPLE_W           = 8;
    localparam int unsigned COEF_W             = 8;
    localparam int unsigned PROD_W             = 16;
    localparam int unsigned INDEX_W            = 8;
    localparam int unsigned COEF_ENTRIES       = 256;

    localparam logic [SAMPLE_W-1:0] SAMPLE_OFFSET = 8'd128;
    localparam logic [COEF_W-1:0]   COEF_UNITY    = 8'd255;
    localparam logic [INDEX_W:0]    FRAME_128     = 9'd128;
    localparam logic [INDEX_W:0]    FRAME_256     = 9'd256;

    typedef struct packed {
        logic signed [PROD_W-1:0] data;
        logic                     last;
    } win_beat_t;

    // Index of the final sample in a frame of the selected length.
    function automatic logic [INDEX_W-1:0] last_index(input logic mode_256);
        return mode_256 ? INDEX_W'(FRAME_256 - 9'd1) : INDEX_W'(FRAME_128 - 9'd1);
    endfunction

    // Signed sample times unsigned Q0.8 coefficient; the full result always fits 16 bits.
    function automatic logic signed [PROD_W-1:0] window_product(
        input logic [SAMPLE_W-1:0] sample_s,
        input logic [COEF_W-1:0]   coef
    );
        logic signed [PROD_W-1:0] s_ext;
        logic signed [PROD_W-1:0] c_ext;
        s_ext = {{(PROD_W-SAMPLE_W){sample_s[SAMPLE_W-1]}}, sample_s};
        c_ext = {{(PROD_W-COEF_W){1'b0}}, coef};
        return s_ext * c_ext;
    endfunction

endpackage

// File: rtl/window_out_fifo.sv
// Show-ahead synchronous FIFO of window beats with occupancy count.
// A write to a full FIFO is legal when a pop happens in the same cycle.
module window_out_fifo
    import window_pkg::*;
#(
    parameter  int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  win_beat_t        wr_data,
    input  logic             rd_en,
    output win_beat_t        rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    win_beat_t         mem_q [DEPTH];
    win_beat_t         mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_rd;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_rd    = rd_en && (count_q != '0);

        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(do_rd);
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/window_multiplier.sv
// Windowing stage: offset-binary to signed conversion, per-position coefficient multiply,
// credit-based flow control toward the framer and an output FIFO for the FFT.
module window_multiplier
    import window_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        use_256_points,
    input  logic        window_valid,
    input  logic [7:0]  window_data,
    output logic        window_ready,
    input  logic        coef_wr_en,
    input  logic [7:0]  coef_wr_addr,
    input  logic [7:0]  coef_wr_data,
    input  logic        fft_ready,
    output logic        fft_valid,
    output logic [15:0] fft_data,
    output logic        fft_last,
    output logic        overflow_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 3);

    logic [INDEX_W-1:0]  sample_idx_q, sample_idx_d;
    logic                frame_256_q, frame_256_d;
    logic                window_ready_q, window_ready_d;
    logic                overflow_q, overflow_d;

    logic                s1_valid_q, s1_valid_d;
    logic [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
    logic [COEF_W-1:0]   s1_coef_q, s1_coef_d;
    logic                s1_last_q, s1_last_d;

    logic                s2_valid_q, s2_valid_d;
    win_beat_t           s2_beat_q, s2_beat_d;

    logic [COEF_W-1:0]   coef_q [COEF_ENTRIES];
    logic [COEF_W-1:0]   coef_d [COEF_ENTRIES];

    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    occ_next;
    logic                accept;
    logic                pop;
    logic                mode_256;
    logic                is_last;
    logic [INDEX_W-1:0]  coef_addr;

    win_beat_t           fifo_head;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    // Frame tracking, credit computation and the two pipeline stages.
    always_comb begin
        sample_idx_d   = sample_idx_q;
        frame_256_d    = frame_256_q;
        window_ready_d = window_ready_q;
        overflow_d     = overflow_q;
        s1_valid_d     = 1'b0;
        s1_sample_d    = s1_sample_q;
        s1_coef_d      = s1_coef_q;
        s1_last_d      = s1_last_q;
        s2_valid_d     = s1_valid_q;
        s2_beat_d      = s2_beat_q;

        occ      = OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q) + OCC_W'(fifo_count);
        pop      = fft_ready && !fifo_empty;
        accept   = window_valid && (occ != OCC_W'(FIFO_DEPTH));
        occ_next = occ + OCC_W'(accept) - OCC_W'(pop);

        // Frame length follows the input only at position 0, then stays frozen.
        mode_256  = (sample_idx_q == '0) ? use_256_points : frame_256_q;
        is_last   = (sample_idx_q == last_index(mode_256));
        coef_addr = mode_256 ? sample_idx_q : {sample_idx_q[INDEX_W-2:0], 1'b0};

        frame_256_d    = mode_256;
        window_ready_d = (occ_next <= OCC_W'(FIFO_DEPTH - 2));
        overflow_d     = overflow_q || (window_valid && !accept);

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_sample_d  = window_data ^ SAMPLE_OFFSET;
            s1_coef_d    = coef_q[coef_addr];
            s1_last_d    = is_last;
            sample_idx_d = is_last ? '0 : sample_idx_q + INDEX_W'(1);
        end

        if (s1_valid_q) begin
            s2_beat_d.data = window_product(s1_sample_q, s1_coef_q);
            s2_beat_d.last = s1_last_q;
        end
    end

    // Coefficient table: a write lands at the edge, so a same-cycle read sees the old value.
    always_comb begin
        coef_d = coef_q;
        if (coef_wr_en) begin
            coef_d[coef_wr_addr] = coef_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_idx_q   <= '0;
            frame_256_q    <= 1'b0;
            window_ready_q <= 1'b0;
            overflow_q     <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_sample_q    <= '0;
            s1_coef_q      <= '0;
            s1_last_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_beat_q      <= '0;
            coef_q         <= '{default: COEF_UNITY};
        end else begin
            sample_idx_q   <= sample_idx_d;
            frame_256_q    <= frame_256_d;
            window_ready_q <= window_ready_d;
            overflow_q     <= overflow_d;
            s1_valid_q     <= s1_valid_d;
            s1_sample_q    <= s1_sample_d;
            s1_coef_q      <= s1_coef_d;
            s1_last_q      <= s1_last_d;
            s2_valid_q     <= s2_valid_d;
            s2_beat_q      <= s2_beat_d;
            coef_q         <= coef_d;
        end
    end

    window_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (s2_valid_q),
        .wr_data (s2_beat_q),
        .rd_en   (fft_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign window_ready = window_ready_q;
    assign overflow_err = overflow_q;
    assign fft_valid    = !fifo_empty;
    assign fft_data     = fifo_head.data;
    assign fft_last     = fifo_head.last;

endmodule

// File: tb/tb_window_multiplier.sv
// Randomised bench for window_multiplier with a transaction-level reference model.
module tb_window_multiplier;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        use_256_points = 1'b0;
    logic        window_valid = 1'b0;
    logic [7:0]  window_data = '0;
    logic        window_ready;
    logic        coef_wr_en = 1'b0;
    logic [7:0]  coef_wr_addr = '0;
    logic [7:0]  coef_wr_data = '0;
    logic        fft_ready = 1'b0;
    logic        fft_valid;
    logic [15:0] fft_data;
    logic        fft_last;
    logic        overflow_err;

    always #5 clk = ~clk;

    window_multiplier #(.FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .use_256_points (use_256_points),
        .window_valid   (window_valid),
        .window_data    (window_data),
        .window_ready   (window_ready),
        .coef_wr_en     (coef_wr_en),
        .coef_wr_addr   (coef_wr_addr),
        .coef_wr_data   (coef_wr_data),
        .fft_ready      (fft_ready),
        .fft_valid      (fft_valid),
        .fft_data       (fft_data),
        .fft_last       (fft_last),
        .overflow_err   (overflow_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted beat becomes an expected output tagged with its accept edge.
    typedef struct {
        int d;
        bit l;
        int e;
    } exp_t;

    exp_t mq[$];
    exp_t m_b;
    int   m_occ, m_edges, m_idx, m_len;
    bit   m_ovf, m_ready, m_pop;
    int   tbl[256];

    int   obs_d[$];
    bit   obs_l[$];

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].e + 2 <= m_edges);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_occ   = 0;
            m_edges = 0;
            m_idx   = 0;
            m_len   = 128;
            m_ovf   = 0;
            m_ready = 0;
            foreach (tbl[i]) tbl[i] = 255;
        end else begin
            m_pop = m_valid() && fft_ready;
            m_edges++;
            if (window_valid) begin
                if (m_occ == D) begin
                    m_ovf = 1;
                end else begin
                    if (m_idx == 0) m_len = use_256_points ? 256 : 128;
                    m_b.d = (int'(window_data) - 128) * tbl[(m_len == 256) ? m_idx : 2 * m_idx];
                    m_b.l = (m_idx == m_len - 1);
                    m_b.e = m_edges;
                    mq.push_back(m_b);
                    m_idx = (m_idx + 1) % m_len;
                    m_occ++;
                end
            end
            if (m_pop) begin
                void'(mq.pop_front());
                m_occ--;
            end
            if (coef_wr_en) tbl[coef_wr_addr] = int'(coef_wr_data);
            m_ready = (m_occ <= D - 2);
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_window_ready", window_ready, 0);
            chk("rst_fft_valid", fft_valid, 0);
            chk("rst_fft_data", fft_data, 0);
            chk("rst_fft_last", fft_last, 0);
            chk("rst_overflow_err", overflow_err, 0);
        end else begin
            chk("window_ready", window_ready, m_ready);
            chk("fft_valid", fft_valid, m_valid());
            if (m_valid()) begin
                chk("fft_data", $signed(fft_data), mq[0].d);
                chk("fft_last", fft_last, mq[0].l);
            end
            chk("overflow_err", overflow_err, m_ovf);
            if (fft_valid && fft_ready) begin
                obs_d.push_back(int'($signed(fft_data)));
                obs_l.push_back(fft_last);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_clear();
        obs_d.delete();
        obs_l.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        window_valid = 1'b0;
        fft_ready    = 1'b1;
        while (mq.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
        chk("drain_empty", fft_valid, 0);
    endtask

    function automatic int count_lasts();
        int c;
        c = 0;
        foreach (obs_l[i]) if (obs_l[i]) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int sent;
    bit last_rdy, rdy_s;

    initial begin
        repeat (3) cyc();
        reset_n = 1'b1;
        chk("ready_before_edge", window_ready, 0);
        cyc();
        chk("ready_after_edge", window_ready, 1);

        // Unity window, 128-point, ramp 0..127.
        use_256_points = 1'b0;
        fft_ready      = 1'b1;
        obs_clear();
        for (int i = 0; i < 128; i++) begin
            window_valid = 1'b1;
            window_data  = 8'(i);
            cyc();
            if (i < 3) chk("latency_valid", fft_valid, (i == 2));
        end
        drain(50);
        chk("unity_count", obs_d.size(), 128);
        if (obs_d.size() == 128) begin
            chk("unity_s0", obs_d[0], -32640);
            chk("unity_s1", obs_d[1], -32385);
            chk("unity_s64", obs_d[64], -16320);
            chk("unity_s127", obs_d[127], -255);
            chk("unity_last_pos", obs_l[127], 1);
        end
        chk("unity_last_count", count_lasts(), 1);

        // Coefficient mapping: coef[2k] = k, constant sample +1.
        for (int a = 0; a < 256; a++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 8'(a);
            coef_wr_data = (a % 2 == 0) ? 8'(a / 2) : 8'hAA;
            cyc();
        end
        coef_wr_en = 1'b0;
        obs_clear();
        for (int i = 0; i < 128; i++) begin
            window_valid = 1'b1;
            window_data  = 8'd129;
            cyc();
        end
        drain(50);
        chk("coef_count", obs_d.size(), 128);
        if (obs_d.size() == 128) begin
            chk("coef_k0", obs_d[0], 0);
            chk("coef_k1", obs_d[1], 1);
            chk("coef_k64", obs_d[64], 64);
            chk("coef_k127", obs_d[127], 127);
            chk("coef_last_pos", obs_l[127], 1);
        end

        // Random coefficients, loaded between frames.
        for (int a = 0; a < 256; a++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 8'(a);
            coef_wr_data = 8'($urandom);
            cyc();
        end
        coef_wr_en = 1'b0;

        // Backpressure with a credit-respecting framer.
        fft_ready = 1'b0;
        sent      = 0;
        last_rdy  = window_ready;
        for (int i = 0; i < 20; i++) begin
            rdy_s        = window_ready;
            window_valid = last_rdy;
            window_data  = 8'($urandom);
            if (window_valid) sent++;
            last_rdy = rdy_s;
            cyc();
        end
        window_valid = 1'b0;
        chk("bp_sent", sent, 8);
        chk("bp_ready_low", window_ready, 0);
        chk("bp_overflow", overflow_err, 0);
        chk("bp_fft_valid", fft_valid, 1);

        // Random traffic: framer obeys credits, sink stalls randomly, mode toggles occasionally.
        for (int i = 0; i < 400; i++) begin
            fft_ready    = ($urandom % 4) != 0;
            rdy_s        = window_ready;
            window_valid = last_rdy && (($urandom % 8) != 0);
            window_data  = 8'($urandom);
            if (($urandom % 64) == 0) use_256_points = ~use_256_points;
            last_rdy = rdy_s;
            cyc();
        end
        drain(50);
        chk("rand_no_overflow", overflow_err, 0);

        // Overflow: ignore credits with the sink stalled.
        fft_ready = 1'b0;
        obs_clear();
        for (int i = 0; i < 10; i++) begin
            window_valid = 1'b1;
            window_data  = 8'($urandom);
            cyc();
        end
        window_valid = 1'b0;
        chk("ovf_set", overflow_err, 1);
        chk("ovf_fft_valid", fft_valid, 1);
        drain(50);
        chk("ovf_kept", obs_d.size(), 8);
        chk("ovf_sticky", overflow_err, 1);

        // Reset mid-frame with three entries waiting.
        fft_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            window_valid = 1'b1;
            window_data  = 8'($urandom);
            cyc();
        end
        window_valid = 1'b0;
        repeat (3) cyc();
        chk("pre_reset_valid", fft_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", fft_valid, 0);
        chk("async_rst_data", fft_data, 0);
        chk("async_rst_last", fft_last, 0);
        chk("async_rst_ready", window_ready, 0);
        chk("async_rst_ovf", overflow_err, 0);
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();

        // Mode change mid-frame: 256-point frame, then a 128-point frame.
        fft_ready      = 1'b1;
        use_256_points = 1'b1;
        obs_clear();
        for (int i = 0; i < 384; i++) begin
            window_valid = 1'b1;
            window_data  = (i == 0) ? 8'd129 : 8'($urandom);
            if (i == 50) use_256_points = 1'b0;
            cyc();
        end
        drain(50);
        chk("mode_count", obs_d.size(), 384);
        if (obs_d.size() == 384) begin
            chk("coef_reset_unity", obs_d[0], 255);
            chk("mode_no_early_last", obs_l[127], 0);
            chk("mode_last_255", obs_l[255], 1);
            chk("mode_last_383", obs_l[383], 1);
        end
        chk("mode_last_count", count_lasts(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_multiplier.md
# window_multiplier

Windowing stage directly downstream of the framer. Takes each framed 8-bit offset-binary sample and converts it to signed. Multiplies it by a per-position coefficient from a writable 256×8 table. Buffers the 16-bit signed products in a small FIFO for the FFT stage, and marks the last sample of each frame. Upstream flow control is credit-style: the framer samples `window_ready` and sends its beat one cycle later.

## Interface
- `FIFO_DEPTH`, 8: output FIFO entries; legal range 4–16.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `use_256_points` in 1: frame length, 1 = 256 samples, 0 = 128 samples.
- `window_valid` in 1: framer sample beat.
- `window_data` in 8: framer sample, offset-binary.
- `window_ready` out 1: registered credit to framer.
- `coef_wr_en` in 1: coefficient table write strobe.
- `coef_wr_addr` in 8: coefficient table address.
- `coef_wr_data` in 8: coefficient, unsigned Q0.8.
- `fft_ready` in 1: downstream accepts the current beat.
- `fft_valid` out 1: output beat valid.
- `fft_data` out 16: signed windowed sample.
- `fft_last` out 1: last sample of frame.
- `overflow_err` out 1: sticky upstream protocol violation.

## Operation
- **Input acceptance.** Every cycle with `window_valid`=1 is an accepted beat; `window_ready` does not qualify it. The beat is registered into stage 1 (s1).
- **Frame position.**
  - `sample_index` (8-bit) counts accepted beats from 0 to N−1, then returns to 0.
  - N is latched from `use_256_points` when `sample_index`=0. Changes mid-frame are ignored until the next frame.
- **Coefficient address.** Equals `sample_index` in 256-point mode and `sample_index`×2 in 128-point mode.
- **Stage 1 (s1).**
  - Sample conversion: `sample_s` = `window_data` with MSB inverted, i.e. `window_data` − 128 as signed 8-bit.
  - Coefficient table is read at the address above.
  - `last` flag = (`sample_index` == N−1).
- **Stage 2 (s2).**
  - Product = `sample_s` (signed 8) × coef (unsigned 8, zero-extended). The result is a full signed 16-bit value in the range −32640..32385, with no rounding or saturation.
  - `{product, last}` is written to the FIFO on the following edge.
- **Coefficient table.**
  - Reset value is 255 in every entry, giving a near-rectangular window.
  - A write takes effect at the edge; a same-cycle read of that address returns the old value.
  - Writes are permitted at any time. Writes during a frame are not guaranteed coherent; software writes only between frames.
- **Occupancy.**
  - `occ` = s1 valid + s2 valid + FIFO count.
  - The pipeline never stalls; credits guarantee space.
  - `window_ready` <= (`occ_next` <= `FIFO_DEPTH`−2), where `occ_next` includes this cycle's accepted beat and pop.
- **Overflow.**
  - A beat accepted when `occ` already equals `FIFO_DEPTH` is dropped and `sample_index` does not advance.
  - `overflow_err` is then set and held until reset.
- **Output.** `fft_valid` = FIFO non-empty. `fft_data` and `fft_last` show the FIFO head. The head is popped on `fft_valid`&&`fft_ready`. `fft_data`/`fft_last` hold stable while `fft_valid`=1 and `fft_ready`=0.

## Timing
- **Reset values.** `window_ready`=0, `fft_valid`=0, `fft_data`=0, `fft_last`=0, `overflow_err`=0, `sample_index`=0, stages and FIFO empty, coefficients 255.
- **After reset release.** `window_ready` rises after the first clock edge.
- **Latency.** A beat sampled at edge e is in s1 after e, in s2 after e+1, and written to the FIFO at e+2. `fft_valid` is high in the cycle after e+2 if the FIFO was empty: 3 edges total.
- **Throughput.** One sample per cycle sustained when `fft_ready`=1.
- **Credit loop.** Up to two beats may arrive after `window_ready` falls; the −2 margin absorbs them.
- **Simultaneous FIFO write and pop.** Count is unchanged; a write to a full FIFO with a same-cycle pop is legal.
- **Reset mid-frame.** Everything is discarded and `sample_index` returns to 0. The coefficient table returns to 255.

## Structure
- Package `window_pkg` holds:
  - `FIFO_DEPTH_DEFAULT`=8
  - `SAMPLE_OFFSET`=8'd128
  - `COEF_UNITY`=8'd255
  - `FRAME_128`/`FRAME_256` constants
  - packed struct `win_beat_t` {`logic signed [15:0] data`; `logic last`}
- One sub-module, `window_out_fifo`: a parameterised synchronous FIFO of `win_beat_t` with count output, asynchronous active-low reset, and show-ahead head.

## Test plan
- **Unity window, 128-point.** Default coefficients, 128-point mode, samples 0..127 with `fft_ready`=1:
  - sample 0 → −128×255 = −32640; sample 128 would give 0.
  - `fft_last` high only on beat 127.
  - First `fft_valid` appears 3 edges after the first beat.
- **Coefficient mapping, 128-point.** Load coef[2k]=k, 128-point mode, all samples 8'd129 → output k on beat k; this confirms ×2 addressing.
- **Backpressure.** `fft_ready`=0 with continuous `window_valid` following the `window_ready` protocol:
  - `window_ready` falls once `occ_next` ≥ 7 (`FIFO_DEPTH`=8).
  - FIFO fills to 8 exactly; no loss and `overflow_err`=0.
  - Releasing `fft_ready` drains in order.
- **Overflow.** `fft_ready`=0 and `window_valid` forced high ignoring ready → 9th beat dropped, `overflow_err`=1 sticky, `sample_index` not advanced.
- **Mode change mid-frame.** `use_256_points` toggles 1→0 at sample 50 of a 256-point frame → `fft_last` still lands on beat 255; next frame has 128 samples.
- **Reset mid-frame.** Assert `reset_n` mid-frame with the FIFO holding 3 entries → all outputs 0 immediately; after release `sample_index`=0 and coefficients are back to 255.
